// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_stream serializer.
// Build option: PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Widest counter any legal WIDTH (2..32) can need, parity included.
  localparam int MAX_WIDTH = 32;
  localparam int MAX_CNT_W = $clog2(MAX_WIDTH + 2);

  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Position-in-frame counter: counts accepted serial beats and flags the last
// beat of a frame. It saturates at LEN-1, so it never exceeds the frame length.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int CNT_W = cnt_width(LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(LEN - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance && !last) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == LAST_VAL);

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with valid/ready on both sides and
// zero-bubble back-to-back frames. Build option: PISO_PARITY_EN.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
  localparam int CNT_W     = cnt_width(FRAME_LEN);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A producer may not retract valid or change data until it is accepted;
  // the serializer holds serial_valid/serial_out stable until serial_ready.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             load_hs;
  logic             ser_hs;
  logic             data_bit;
  logic             cur_bit;

  assign serial_valid = (state == SHIFT);
  assign busy         = (state == SHIFT);
  assign ser_hs       = serial_valid && serial_ready;

  // Accepting on the last beat of a frame is what keeps frames contiguous.
  assign load_ready = !reset &&
                      ((state == IDLE) || (serial_valid && last_bit && serial_ready));
  assign load_hs    = load_valid && load_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_hs) state_next = SHIFT;
      SHIFT:   if (ser_hs && last_bit && !load_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (load_hs) begin
      shift_reg <= parallel_in;
    end else if (ser_hs && !last_bit) begin
      shift_reg <= MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                             : {1'b0, shift_reg[WIDTH-1:1]};
    end
  end

  assign data_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

`ifdef PISO_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (load_hs) begin
      parity_bit <= ^parallel_in;
    end
  end

  // Beat WIDTH is the appended parity position.
  assign cur_bit = (bit_cnt == CNT_W'(WIDTH)) ? parity_bit : data_bit;
`else
  assign cur_bit = data_bit;
`endif

  piso_bit_counter #(
    .LEN   (FRAME_LEN),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (load_hs || (ser_hs && last_bit)),
    .advance (ser_hs),
    .count   (bit_cnt),
    .last    (last_bit)
  );

  assign serial_out  = serial_valid && cur_bit;
  assign frame_start = serial_valid && (bit_cnt == '0);
  assign frame_end   = serial_valid && last_bit;

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: an LSB-first and an MSB-first instance
// share stimulus and are checked against a word-to-bit-list reference model.
module tb_piso_stream;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] parallel_in = '0;
  logic             serial_ready = 1'b0;

  // index 0: LSB-first instance, index 1: MSB-first instance
  logic [1:0] load_ready;
  logic [1:0] serial_out;
  logic [1:0] serial_valid;
  logic [1:0] frame_start;
  logic [1:0] frame_end;
  logic [1:0] busy;

  int n_cmp = 0;
  int n_err = 0;

  piso_stream #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready[0]),
    .parallel_in  (parallel_in),
    .serial_out   (serial_out[0]),
    .serial_valid (serial_valid[0]),
    .serial_ready (serial_ready),
    .frame_start  (frame_start[0]),
    .frame_end    (frame_end[0]),
    .busy         (busy[0])
  );

  piso_stream #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready[1]),
    .parallel_in  (parallel_in),
    .serial_out   (serial_out[1]),
    .serial_valid (serial_valid[1]),
    .serial_ready (serial_ready),
    .frame_start  (frame_start[1]),
    .frame_end    (frame_end[1]),
    .busy         (busy[1])
  );

  // ---------------- reference model ----------------
  // Bit i of the frame for word w: data bits in the chosen order, then parity.
  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int i, input bit msb);
    if (i >= WIDTH) return ^w;
    return msb ? w[WIDTH-1-i] : w[i];
  endfunction

  // {serial_valid, serial_out, frame_start, frame_end, busy}
  function automatic logic [4:0] obs(input int k);
    return {serial_valid[k], serial_out[k], frame_start[k], frame_end[k], busy[k]};
  endfunction

  function automatic logic [4:0] exp_shift(input logic [WIDTH-1:0] w, input int i, input int k);
    return {1'b1, exp_bit(w, i, k == 1), i == 0, i == FL - 1, 1'b1};
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [WIDTH-1:0] w);
    load_valid  = 1'b1;
    parallel_in = w;
    step();
    load_valid  = 1'b0;
    parallel_in = WIDTH'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b1;
    serial_ready = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({load_ready[k], obs(k)} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_hold inst=%0d got=%b want=000000", k, {load_ready[k], obs(k)});
      end
    end
    load_valid = 1'b0;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({load_ready[k], obs(k)} !== 6'b100000) begin
        n_err++;
        $display("FAIL reset_release inst=%0d got=%b want=100000", k, {load_ready[k], obs(k)});
      end
    end
  endtask

  task automatic test_single_frame(input logic [WIDTH-1:0] w);
    serial_ready = 1'b1;
    load_valid = 1'b1;
    parallel_in = w;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (load_ready[k] !== 1'b1) begin
        n_err++;
        $display("FAIL idle_load_ready inst=%0d got=%b want=1", k, load_ready[k]);
      end
    end
    step();
    load_valid = 1'b0;
    parallel_in = WIDTH'($urandom);
    for (int i = 0; i < FL; i++) begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== exp_shift(w, i, k)) begin
          n_err++;
          $display("FAIL single_frame word=%h inst=%0d bit=%0d got=%b want=%b",
                   w, k, i, obs(k), exp_shift(w, i, k));
        end
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({load_ready[k], obs(k)} !== 6'b100000) begin
        n_err++;
        $display("FAIL frame_done_idle word=%h inst=%0d got=%b want=100000",
                 w, k, {load_ready[k], obs(k)});
      end
    end
  endtask

  task automatic test_back_to_back(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1);
    logic [WIDTH-1:0] w;
    serial_ready = 1'b1;
    load_word(w0);
    load_valid = 1'b1;
    parallel_in = w1;
    for (int c = 0; c < 2 * FL; c++) begin
      w = (c < FL) ? w0 : w1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({load_ready[k], obs(k)} !== {(c % FL) == FL - 1, exp_shift(w, c % FL, k)}) begin
          n_err++;
          $display("FAIL back_to_back words=%h,%h inst=%0d beat=%0d got=%b want=%b",
                   w0, w1, k, c, {load_ready[k], obs(k)},
                   {(c % FL) == FL - 1, exp_shift(w, c % FL, k)});
        end
      end
      step();
      if (c == FL - 1) begin
        load_valid = 1'b0;
        parallel_in = WIDTH'($urandom);
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== 5'b0) begin
        n_err++;
        $display("FAIL back_to_back_idle inst=%0d got=%b want=00000", k, obs(k));
      end
    end
  endtask

  // Stalls the sink with the fixed 1,0,0,1 pattern or with random ready.
  task automatic test_stall(input logic [WIDTH-1:0] w, input bit random_mode);
    logic [3:0] pat = 4'b1001;
    logic       exp_q[2][$];
    logic       b;
    int         cyc = 0;
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      for (int i = 0; i < FL; i++) exp_q[k].push_back(exp_bit(w, i, k == 1));
    end
    serial_ready = 1'b1;
    load_word(w);
    while (exp_q[1].size() > 0 && cyc < 20 * FL) begin
      serial_ready = random_mode ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
      for (int k = 0; k < 2; k++) begin
        b = exp_q[k][0];
        n_cmp++;
        if (obs(k) !== {1'b1, b, exp_q[k].size() == FL, exp_q[k].size() == 1, 1'b1}) begin
          n_err++;
          $display("FAIL stall word=%h inst=%0d cycle=%0d got=%b want=%b", w, k, cyc, obs(k),
                   {1'b1, b, exp_q[k].size() == FL, exp_q[k].size() == 1, 1'b1});
        end
      end
      step();
      if (serial_ready) begin
        void'(exp_q[0].pop_front());
        void'(exp_q[1].pop_front());
      end
      cyc++;
    end
    n_cmp++;
    if (exp_q[1].size() != 0) begin
      n_err++;
      $display("FAIL stall_timeout word=%h got=%0d bits_left want=0", w, exp_q[1].size());
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== 5'b0) begin
        n_err++;
        $display("FAIL stall_idle word=%h inst=%0d got=%b want=00000", w, k, obs(k));
      end
    end
    serial_ready = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    serial_ready = 1'b1;
    load_word(8'hFF);
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({load_ready[k], obs(k)} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_mid_frame inst=%0d got=%b want=000000", k, {load_ready[k], obs(k)});
      end
    end
    step();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({load_ready[k], obs(k)} !== 6'b100000) begin
        n_err++;
        $display("FAIL reset_mid_release inst=%0d got=%b want=100000", k, {load_ready[k], obs(k)});
      end
    end
    test_single_frame(8'h0F);
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] words [2] = '{8'h07, 8'h03};
    logic             par   [2] = '{1'b1, 1'b0};
    serial_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      load_word(words[n]);
      for (int i = 0; i < FL - 1; i++) step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({serial_valid[k], serial_out[k], frame_end[k]} !== {1'b1, par[n], 1'b1}) begin
          n_err++;
          $display("FAIL parity word=%h inst=%0d got=%b want=%b", words[n], k,
                   {serial_valid[k], serial_out[k], frame_end[k]}, {1'b1, par[n], 1'b1});
        end
      end
      step();
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame(8'hA5);
    test_single_frame(8'h01);
    test_back_to_back(8'h3C, 8'hC3);
    test_stall(8'h96, 1'b0);
    test_reset_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    for (int n = 0; n < 6; n++) begin
      test_single_frame(WIDTH'($urandom));
      test_back_to_back(WIDTH'($urandom), WIDTH'($urandom));
      test_stall(WIDTH'($urandom), 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
